// File: rtl/pwm_param_calc_if.sv
// pwm_param_calc_if
//   Groups the request handshake coming from the UDP parameter parser and the
//   configuration strobe going to the PWM channel array.
//
//   Request side (requester -> calculator):
//     cfg_vld            request valid
//     cfg_rdy            request ready, high only while the calculator is idle
//     cfg_channel [7:0]  target channel index
//     cfg_en             PWM output enable
//     cfg_freq   [31:0]  output frequency in Hz
//     cfg_duty   [7:0]   duty cycle in percent (values above 100 are clamped)
//
//   Result side (calculator -> PWM channels):
//     pwm_config_vld     one-cycle configuration strobe
//     pwm_config_channel channel addressed by the strobe
//     pwm_en             enable for that channel
//     pwm_period [27:0]  clock counts per PWM period
//     pwm_hlevel [27:0]  clock counts of high level
//     cfg_err            one-cycle pulse when a request is rejected
//
//   master : the requester / result consumer side (testbench, parser)
//   slave  : the calculator itself
interface pwm_param_calc_if;

  logic        cfg_vld;
  logic        cfg_rdy;
  logic [7:0]  cfg_channel;
  logic        cfg_en;
  logic [31:0] cfg_freq;
  logic [7:0]  cfg_duty;
  logic        pwm_config_vld;
  logic [7:0]  pwm_config_channel;
  logic        pwm_en;
  logic [27:0] pwm_period;
  logic [27:0] pwm_hlevel;
  logic        cfg_err;

  modport master (
    output cfg_vld, cfg_channel, cfg_en, cfg_freq, cfg_duty,
    input  cfg_rdy, pwm_config_vld, pwm_config_channel, pwm_en,
           pwm_period, pwm_hlevel, cfg_err
  );

  modport slave (
    input  cfg_vld, cfg_channel, cfg_en, cfg_freq, cfg_duty,
    output cfg_rdy, pwm_config_vld, pwm_config_channel, pwm_en,
           pwm_period, pwm_hlevel, cfg_err
  );

endinterface

// File: rtl/pwm_param_calc.sv
// pwm_param_calc
//   Turns one PWM request (frequency in Hz, duty in percent, enable) into the
//   clock-count parameters used by the PWM channel array:
//     period = min(CLK_FREQ / freq, 0x0FFFFFFF)
//     hlevel = floor(period * min(duty, 100) / 100)
//   The arithmetic is sequential: a 32-step restoring divider, a 7-step
//   shift-add multiplier and a 35-step restoring divider by 100, so the
//   latency is fixed by the path taken and never by the operand values.
//
//   Ports:
//     clk  module clock
//     rst  synchronous, active-high reset
//     bus  pwm_param_calc_if.slave (request handshake + configuration strobe)
//
//   Parameters:
//     CLK_FREQ  PWM module clock in Hz (below 2^32)
//     CH_NUM    number of PWM channels, valid indices 0..CH_NUM-1
module pwm_param_calc #(
  parameter logic [31:0] CLK_FREQ = 32'd100_000_000,
  parameter int          CH_NUM   = 8
) (
  input logic             clk,
  input logic             rst,
  pwm_param_calc_if.slave bus
);

  localparam logic [8:0]  LP_CH_NUM     = 9'(CH_NUM);
  localparam logic [27:0] LP_PERIOD_MAX = 28'hFFF_FFFF;
  localparam logic [7:0]  LP_PERCENT    = 8'd100;
  localparam logic [5:0]  LP_DIV1_LAST  = 6'd31;
  localparam logic [5:0]  LP_MUL_LAST   = 6'd6;
  localparam logic [5:0]  LP_DIV2_LAST  = 6'd34;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV1,
    S_MUL,
    S_DIV2,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [5:0]  r_cnt;
  logic [7:0]  r_chan;
  logic        r_en;
  logic [31:0] r_freq;
  logic [6:0]  r_duty;
  logic [31:0] r_rem1;
  logic [31:0] r_quo1;
  logic [27:0] r_period;
  logic [34:0] r_mcand;
  logic [34:0] r_acc;
  logic [6:0]  r_rem2;

  logic [7:0]  r_outChan;
  logic        r_outEn;
  logic [27:0] r_outPeriod;
  logic [27:0] r_outHlevel;

  logic        w_reqBad;
  logic [32:0] w_trial1;
  logic        w_ge1;
  logic [31:0] w_rem1Next;
  logic [31:0] w_quo1Next;
  logic [27:0] w_periodSat;
  logic [7:0]  w_trial2;
  logic        w_ge2;
  logic [6:0]  w_rem2Next;
  logic [34:0] w_acc2Next;

  // Request screening and the single step of each restoring divider.
  // The divider registers hold the dividend and shift the quotient bits in
  // from the bottom, so after the last step the register is the quotient.
  // The "next" values are exposed so the FSM can judge the final quotient
  // in the same cycle the last bit is produced.
  always_comb begin
    w_reqBad    = ({1'b0, bus.cfg_channel} >= LP_CH_NUM) || (bus.cfg_freq == 32'd0);

    w_trial1    = {r_rem1, r_quo1[31]};
    w_ge1       = (w_trial1 >= {1'b0, r_freq});
    // When the trial value reaches the divisor the true difference is below
    // the divisor, so a 32-bit subtraction is exact.
    w_rem1Next  = w_ge1 ? (w_trial1[31:0] - r_freq) : w_trial1[31:0];
    w_quo1Next  = {r_quo1[30:0], w_ge1};
    w_periodSat = (|w_quo1Next[31:28]) ? LP_PERIOD_MAX : w_quo1Next[27:0];

    w_trial2    = {r_rem2, r_acc[34]};
    w_ge2       = (w_trial2 >= LP_PERCENT);
    w_rem2Next  = w_ge2 ? 7'(w_trial2 - LP_PERCENT) : w_trial2[6:0];
    w_acc2Next  = {r_acc[33:0], w_ge2};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. Each arithmetic phase lasts a fixed number of cycles
  // counted by r_cnt, which restarts on every state change.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cfg_vld) begin
          if (w_reqBad) begin
            w_stateNext = S_ERR;
          end else if (!bus.cfg_en) begin
            w_stateNext = S_DONE;
          end else begin
            w_stateNext = S_DIV1;
          end
        end
      end
      S_DIV1: begin
        if (r_cnt == LP_DIV1_LAST) begin
          w_stateNext = (w_quo1Next == 32'd0) ? S_ERR : S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == LP_MUL_LAST) begin
          w_stateNext = S_DIV2;
        end
      end
      S_DIV2: begin
        if (r_cnt == LP_DIV2_LAST) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      S_ERR:   w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Datapath: request latch, divider/multiplier iterations, and the output
  // registers. The output registers are only written on the edge that enters
  // DONE, which is what keeps them unchanged across rejected requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_chan      <= '0;
      r_en        <= 1'b0;
      r_freq      <= '0;
      r_duty      <= '0;
      r_rem1      <= '0;
      r_quo1      <= '0;
      r_period    <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_rem2      <= '0;
      r_outChan   <= '0;
      r_outEn     <= 1'b0;
      r_outPeriod <= '0;
      r_outHlevel <= '0;
    end else begin
      if (r_state != w_stateNext) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.cfg_vld) begin
            r_chan <= bus.cfg_channel;
            r_en   <= bus.cfg_en;
            r_freq <= bus.cfg_freq;
            r_duty <= (bus.cfg_duty > LP_PERCENT) ? 7'd100 : bus.cfg_duty[6:0];
            r_rem1 <= '0;
            r_quo1 <= CLK_FREQ;
            // A disabled channel skips the arithmetic and reports zero counts.
            if (!w_reqBad && !bus.cfg_en) begin
              r_outChan   <= bus.cfg_channel;
              r_outEn     <= 1'b0;
              r_outPeriod <= '0;
              r_outHlevel <= '0;
            end
          end
        end
        S_DIV1: begin
          r_rem1 <= w_rem1Next;
          r_quo1 <= w_quo1Next;
          if (r_cnt == LP_DIV1_LAST) begin
            r_period <= w_periodSat;
            r_mcand  <= {7'd0, w_periodSat};
            r_acc    <= '0;
          end
        end
        S_MUL: begin
          // LSB-first shift-add: each duty bit adds the suitably shifted period.
          if (r_duty[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_duty  <= r_duty >> 1;
          if (r_cnt == LP_MUL_LAST) begin
            r_rem2 <= '0;
          end
        end
        S_DIV2: begin
          r_rem2 <= w_rem2Next;
          r_acc  <= w_acc2Next;
          // The product never exceeds period * 100, so the quotient fits 28 bits.
          if (r_cnt == LP_DIV2_LAST) begin
            r_outChan   <= r_chan;
            r_outEn     <= r_en;
            r_outPeriod <= r_period;
            r_outHlevel <= w_acc2Next[27:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: handshake and pulses decode straight from the state register,
  // the configuration values come from the held output registers.
  always_comb begin
    bus.cfg_rdy            = (r_state == S_IDLE);
    bus.pwm_config_vld     = (r_state == S_DONE);
    bus.cfg_err            = (r_state == S_ERR);
    bus.pwm_config_channel = r_outChan;
    bus.pwm_en             = r_outEn;
    bus.pwm_period         = r_outPeriod;
    bus.pwm_hlevel         = r_outHlevel;
  end

endmodule

// File: tb/tb_pwm_param_calc.sv
// tb_pwm_param_calc
//   Self-checking bench for pwm_param_calc. Directed requests from the test
//   plan plus randomized requests are compared against a behavioural model
//   that computes the expected path, latency and counts with plain 64-bit
//   arithmetic. Inputs are driven and outputs sampled on the falling edge;
//   cycle N is the clock period following the Nth rising edge after the
//   acceptance edge.
module tb_pwm_param_calc;

  localparam logic [31:0] CLK_FREQ = 32'd100_000_000;
  localparam int          CH_NUM   = 8;

  logic clk = 1'b0;
  logic rst;

  pwm_param_calc_if bus ();

  pwm_param_calc #(
    .CLK_FREQ(CLK_FREQ),
    .CH_NUM  (CH_NUM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model copy of the last issued configuration (what the outputs must hold).
  logic [7:0]  heldCh;
  logic        heldEn;
  logic [27:0] heldPer;
  logic [27:0] heldHl;

  // Scratch for the multi-request sequences.
  int          sCyc [2];
  logic [7:0]  sCh  [2];
  logic        sEn  [2];
  logic [27:0] sPer [2];
  logic [27:0] sHl  [2];

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Behavioural model: which path a request takes, in which cycle its
  // strobe or error appears, and the resulting counts.
  task automatic calcExpected(input logic [7:0] ch, input logic en,
                              input logic [31:0] freq, input logic [7:0] duty,
                              output bit expErr, output int expCyc,
                              output logic [27:0] expPer, output logic [27:0] expHl);
    longint unsigned q;
    longint unsigned d;
    expErr = 1'b0;
    expCyc = 75;
    expPer = '0;
    expHl  = '0;
    if (int'(ch) >= CH_NUM || freq == 32'd0) begin
      expErr = 1'b1;
      expCyc = 1;
    end else if (!en) begin
      expCyc = 1;
    end else begin
      q = 64'(CLK_FREQ) / 64'(freq);
      if (q == 0) begin
        expErr = 1'b1;
        expCyc = 33;
      end else begin
        if (q > 64'h0FFF_FFFF) q = 64'h0FFF_FFFF;
        d = (duty > 8'd100) ? 64'd100 : 64'(duty);
        expPer = 28'(q);
        expHl  = 28'((q * d) / 100);
      end
    end
  endtask

  // Presents one request while the DUT is idle and returns in cycle 1.
  task automatic applyStimulus(input logic [7:0] ch, input logic en,
                               input logic [31:0] freq, input logic [7:0] duty);
    @(negedge clk);
    checkOutput("rdyIdle", 64'(bus.cfg_rdy), 64'd1);
    bus.cfg_channel = ch;
    bus.cfg_en      = en;
    bus.cfg_freq    = freq;
    bus.cfg_duty    = duty;
    bus.cfg_vld     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_vld = 1'b0;
  endtask

  // Full request: stimulus, bounded observation until cfg_rdy returns,
  // then compare path, timing, strobe contents and held outputs.
  task automatic runRequest(input logic [7:0] ch, input logic en,
                            input logic [31:0] freq, input logic [7:0] duty);
    bit          expErr;
    int          expCyc;
    logic [27:0] expPer;
    logic [27:0] expHl;
    int          cyc, strobeCyc, errCyc, rdyCyc, nStrobe, nErr, nBoth;
    logic [7:0]  gotCh;
    logic        gotEn;
    logic [27:0] gotPer, gotHl;

    calcExpected(ch, en, freq, duty, expErr, expCyc, expPer, expHl);
    applyStimulus(ch, en, freq, duty);
    checkOutput("rdyBusy", 64'(bus.cfg_rdy), 64'd0);

    cyc = 1; strobeCyc = 0; errCyc = 0; rdyCyc = 0;
    nStrobe = 0; nErr = 0; nBoth = 0;
    gotCh = '0; gotEn = 1'b0; gotPer = '0; gotHl = '0;
    while (rdyCyc == 0 && cyc <= 200) begin
      if (bus.pwm_config_vld) begin
        nStrobe++;
        strobeCyc = cyc;
        gotCh  = bus.pwm_config_channel;
        gotEn  = bus.pwm_en;
        gotPer = bus.pwm_period;
        gotHl  = bus.pwm_hlevel;
      end
      if (bus.cfg_err) begin
        nErr++;
        errCyc = cyc;
      end
      if (bus.pwm_config_vld && bus.cfg_err) nBoth++;
      if (bus.cfg_rdy) begin
        rdyCyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end

    checkOutput("strobeCount", 64'(nStrobe), expErr ? 64'd0 : 64'd1);
    checkOutput("errCount", 64'(nErr), expErr ? 64'd1 : 64'd0);
    checkOutput("overlap", 64'(nBoth), 64'd0);
    if (expErr) begin
      checkOutput("errCycle", 64'(errCyc), 64'(expCyc));
    end else begin
      checkOutput("strobeCycle", 64'(strobeCyc), 64'(expCyc));
      checkOutput("strobeCh", 64'(gotCh), 64'(ch));
      checkOutput("strobeEn", 64'(gotEn), 64'(en));
      checkOutput("strobePeriod", 64'(gotPer), 64'(expPer));
      checkOutput("strobeHlevel", 64'(gotHl), 64'(expHl));
      heldCh = ch; heldEn = en; heldPer = expPer; heldHl = expHl;
    end
    checkOutput("rdyCycle", 64'(rdyCyc), 64'(expCyc + 1));
    checkOutput("holdCh", 64'(bus.pwm_config_channel), 64'(heldCh));
    checkOutput("holdEn", 64'(bus.pwm_en), 64'(heldEn));
    checkOutput("holdPeriod", 64'(bus.pwm_period), 64'(heldPer));
    checkOutput("holdHlevel", 64'(bus.pwm_hlevel), 64'(heldHl));
  endtask

  bit          bErr;
  int          bCyc;
  logic [27:0] bPerA, bHlA, bPerB, bHlB;
  int          nStrobe, nErr;
  logic        rdy76, rdy77;
  logic [7:0]  rCh;
  logic        rEn;
  logic [31:0] rFreq;
  logic [7:0]  rDuty;

  // Linear sequence of directed steps followed by randomized requests.
  initial begin
    rst             = 1'b1;
    bus.cfg_vld     = 1'b0;
    bus.cfg_channel = '0;
    bus.cfg_en      = 1'b0;
    bus.cfg_freq    = '0;
    bus.cfg_duty    = '0;
    heldCh = '0; heldEn = 1'b0; heldPer = '0; heldHl = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstRdy", 64'(bus.cfg_rdy), 64'd1);
    checkOutput("rstVld", 64'(bus.pwm_config_vld), 64'd0);
    checkOutput("rstErr", 64'(bus.cfg_err), 64'd0);
    checkOutput("rstCh", 64'(bus.pwm_config_channel), 64'd0);
    checkOutput("rstEn", 64'(bus.pwm_en), 64'd0);
    checkOutput("rstPeriod", 64'(bus.pwm_period), 64'd0);
    checkOutput("rstHlevel", 64'(bus.pwm_hlevel), 64'd0);
    rst = 1'b0;

    // Directed requests from the test plan.
    $display("[TB] directed requests");
    runRequest(8'd2, 1'b1, 32'd1000, 8'd25);
    runRequest(8'd0, 1'b1, 32'd3, 8'd33);
    runRequest(8'd1, 1'b1, 32'd3, 8'd150);
    runRequest(8'd8, 1'b1, 32'd1000, 8'd50);
    runRequest(8'd3, 1'b1, 32'd0, 8'd50);
    runRequest(8'd4, 1'b1, 32'd200_000_000, 8'd50);
    runRequest(8'd5, 1'b0, 32'd1000, 8'd60);
    runRequest(8'd7, 1'b1, 32'd1, 8'd100);

    // Back-to-back: cfg_vld stays high, the second request waits in line.
    $display("[TB] back-to-back requests");
    calcExpected(8'd1, 1'b1, 32'd50_000, 8'd40, bErr, bCyc, bPerA, bHlA);
    calcExpected(8'd6, 1'b1, 32'd123_457, 8'd77, bErr, bCyc, bPerB, bHlB);
    @(negedge clk);
    bus.cfg_channel = 8'd1; bus.cfg_en = 1'b1;
    bus.cfg_freq = 32'd50_000; bus.cfg_duty = 8'd40;
    bus.cfg_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_channel = 8'd6; bus.cfg_freq = 32'd123_457; bus.cfg_duty = 8'd77;
    nStrobe = 0; nErr = 0; rdy76 = 1'b0; rdy77 = 1'b1;
    sCyc[0] = 0; sCyc[1] = 0;
    for (int c = 1; c <= 160; c++) begin
      if (bus.pwm_config_vld) begin
        if (nStrobe < 2) begin
          sCyc[nStrobe] = c;
          sCh[nStrobe]  = bus.pwm_config_channel;
          sEn[nStrobe]  = bus.pwm_en;
          sPer[nStrobe] = bus.pwm_period;
          sHl[nStrobe]  = bus.pwm_hlevel;
        end
        nStrobe++;
      end
      if (bus.cfg_err) nErr++;
      if (c == 76) rdy76 = bus.cfg_rdy;
      if (c == 77) begin
        rdy77 = bus.cfg_rdy;
        bus.cfg_vld = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("b2bStrobes", 64'(nStrobe), 64'd2);
    checkOutput("b2bErrs", 64'(nErr), 64'd0);
    checkOutput("b2bRdy76", 64'(rdy76), 64'd1);
    checkOutput("b2bRdy77", 64'(rdy77), 64'd0);
    checkOutput("b2bCycA", 64'(sCyc[0]), 64'd75);
    checkOutput("b2bPerA", 64'(sPer[0]), 64'(bPerA));
    checkOutput("b2bHlA", 64'(sHl[0]), 64'(bHlA));
    checkOutput("b2bCycB", 64'(sCyc[1]), 64'd151);
    checkOutput("b2bChB", 64'(sCh[1]), 64'd6);
    checkOutput("b2bEnB", 64'(sEn[1]), 64'd1);
    checkOutput("b2bPerB", 64'(sPer[1]), 64'(bPerB));
    checkOutput("b2bHlB", 64'(sHl[1]), 64'(bHlB));
    heldCh = 8'd6; heldEn = 1'b1; heldPer = bPerB; heldHl = bHlB;

    // Reset in cycle 40 of a normal request aborts it silently.
    $display("[TB] reset mid-operation");
    applyStimulus(8'd3, 1'b1, 32'd2000, 8'd50);
    nStrobe = 0; nErr = 0;
    for (int c = 1; c < 40; c++) begin
      if (bus.pwm_config_vld) nStrobe++;
      if (bus.cfg_err) nErr++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstRdy", 64'(bus.cfg_rdy), 64'd1);
    checkOutput("midRstCh", 64'(bus.pwm_config_channel), 64'd0);
    checkOutput("midRstEn", 64'(bus.pwm_en), 64'd0);
    checkOutput("midRstPeriod", 64'(bus.pwm_period), 64'd0);
    checkOutput("midRstHlevel", 64'(bus.pwm_hlevel), 64'd0);
    rst = 1'b0;
    heldCh = '0; heldEn = 1'b0; heldPer = '0; heldHl = '0;
    for (int c = 0; c < 80; c++) begin
      if (bus.pwm_config_vld) nStrobe++;
      if (bus.cfg_err) nErr++;
      @(negedge clk);
    end
    checkOutput("midRstStrobes", 64'(nStrobe), 64'd0);
    checkOutput("midRstErrs", 64'(nErr), 64'd0);
    runRequest(8'd3, 1'b1, 32'd2000, 8'd50);

    // Randomized requests against the model.
    $display("[TB] randomized requests");
    for (int i = 0; i < 10; i++) begin
      rCh  = 8'($urandom_range(0, 9));
      rEn  = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 4))
        0:       rFreq = 32'($urandom_range(1, 100));
        1:       rFreq = 32'($urandom_range(1, 1_000_000));
        2:       rFreq = 32'($urandom_range(1, 200_000_000));
        3:       rFreq = 32'd0;
        default: rFreq = 32'($urandom_range(1000, 50_000));
      endcase
      rDuty = 8'($urandom_range(0, 255));
      runRequest(rCh, rEn, rFreq, rDuty);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
